// File: rtl/dco_pkg.sv
// Shared constants and types for the DPLL digitally controlled oscillator.
// The counter step constants define how far the phase counter moves per
// clk cycle for a nominal, advanced or retarded cycle.
package dco_pkg;

    localparam int DCO_PERIOD_DEF = 16;

    localparam int STEP_NOM = 1;
    localparam int STEP_ADV = 2;
    localparam int STEP_RET = 0;

    typedef enum logic [1:0] {
        CORR_NONE = 2'd0,
        CORR_ADV  = 2'd1,
        CORR_RET  = 2'd2
    } corr_t;

    // Simultaneous advance and retard requests cancel each other out.
    function automatic corr_t corrSel(input logic addEdge, input logic subEdge);
        corr_t sel;
        sel = CORR_NONE;
        if (addEdge && !subEdge) begin
            sel = CORR_ADV;
        end else if (!addEdge && subEdge) begin
            sel = CORR_RET;
        end
        return sel;
    endfunction

endpackage

// File: rtl/dco_edge_det.sv
// One-bit rising-edge detector used to turn add/sub request levels into
// single-cycle correction strobes. Only used when DCO_LEVEL_CORR_EN is not
// defined.
module dco_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic i_level,
    output logic o_rise
);

    logic r_prev;

    // Remember last cycle's level so a new rising edge can be spotted.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= i_level;
        end
    end

    assign o_rise = i_level & ~r_prev;

endmodule

// File: rtl/dco_1.sv
// Digitally controlled oscillator for the DPLL loop.
// dco_clk is the MSB of a free-running phase counter that wraps every PERIOD
// clk cycles. An add request inserts a count (phase advance by one clk), a
// sub request deletes one (phase retard by one clk).
// Macro DCO_LEVEL_CORR_EN: when defined, corrections are applied on every
// cycle add/sub is high instead of once per rising edge.
// Note: rst_n is an active-high asynchronous reset despite its name.
module dco_1
    import dco_pkg::*;
#(
    parameter  int PERIOD = DCO_PERIOD_DEF,
    localparam int CNT_W  = $clog2(PERIOD)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic add,
    input  logic sub,
    output logic dco_clk
);

    logic             w_addEdge;
    logic             w_subEdge;
    corr_t            w_corr;
    logic [CNT_W-1:0] w_step;
    logic [CNT_W-1:0] r_cnt;

`ifdef DCO_LEVEL_CORR_EN
    assign w_addEdge = add;
    assign w_subEdge = sub;
`else
    dco_edge_det u_addDet (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_level (add),
        .o_rise  (w_addEdge)
    );

    dco_edge_det u_subDet (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_level (sub),
        .o_rise  (w_subEdge)
    );
`endif

    assign w_corr = corrSel(w_addEdge, w_subEdge);

    // Pick this cycle's counter increment from the requested correction.
    always_comb begin
        w_step = CNT_W'(STEP_NOM);
        case (w_corr)
            CORR_ADV: w_step = CNT_W'(STEP_ADV);
            CORR_RET: w_step = CNT_W'(STEP_RET);
            default:  w_step = CNT_W'(STEP_NOM);
        endcase
    end

    // Phase counter; wraps naturally because PERIOD is a power of two.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + w_step;
        end
    end

    // Output straight from a register bit so it can never glitch.
    assign dco_clk = r_cnt[CNT_W-1];

endmodule

// File: tb/tb_dco_1.sv
// Self-checking bench for dco_1 (PERIOD=16, clk period 20 ns).
// Stimulus pushes the expected length (in clk cycles) of each upcoming
// dco_clk period; the monitor measures the interval between dco_clk rising
// edges and pops/compares. Honours DCO_LEVEL_CORR_EN for held requests.
`timescale 1ns/1ps
module tb_dco_1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic add   = 1'b0;
    logic sub   = 1'b0;
    logic dco_clk;

    int   assertCount   = 0;
    int   failCount     = 0;
    int   expQ[$];
    int   expectedRises = 0;
    int   riseCount     = 0;
    int   cyc           = 0;
    int   lastRise      = 0;
    logic prevD         = 1'b0;

    dco_1 #(.PERIOD(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .add     (add),
        .sub     (sub),
        .dco_clk (dco_clk)
    );

    // 50 MHz system clock.
    always #10 clk = ~clk;

    task automatic checkOutput(input string name, input int act, input int exp);
        assertCount++;
        if (act != exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic finishTest;
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    endtask

    task automatic expectPeriod(input int len);
        expQ.push_back(len);
        expectedRises++;
    endtask

    function automatic logic inTrain(input int t, input int start, input int len,
                                     input int pitch, input int count);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < count; k++) begin
            if (t >= start + k * pitch && t < start + k * pitch + len) hit = 1'b1;
        end
        return hit;
    endfunction

    // Block until every expected rising edge has been observed, bounded.
    task automatic waitAllRises;
        int guard;
        guard = 0;
        while (riseCount < expectedRises && guard < 200) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (riseCount < expectedRises) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL riseTimeout: got %0d rises, expected %0d", riseCount, expectedRises);
            finishTest();
        end
    endtask

    // Drive pulse trains on add/sub; t=0 is the cycle right after a dco_clk rise.
    task automatic applyStimulus(input int aStart, input int aLen, input int aPitch, input int aCount,
                                 input int sStart, input int sLen, input int sPitch, input int sCount);
        int lastT;
        int sEnd;
        lastT = (aCount > 0) ? aStart + (aCount - 1) * aPitch + aLen : 0;
        sEnd  = (sCount > 0) ? sStart + (sCount - 1) * sPitch + sLen : 0;
        if (sEnd > lastT) lastT = sEnd;
        for (int t = 0; t <= lastT; t++) begin
            add = inTrain(t, aStart, aLen, aPitch, aCount);
            sub = inTrain(t, sStart, sLen, sPitch, sCount);
            @(negedge clk);
        end
        add = 1'b0;
        sub = 1'b0;
    endtask

    // Monitor: measure rise-to-rise intervals and score them against the queue.
    always @(negedge clk) begin
        int interval;
        int expLen;
        cyc++;
        if (rst_n) begin
            lastRise = cyc;
            prevD    = 1'b0;
        end else begin
            if (dco_clk === 1'b1 && prevD == 1'b0) begin
                riseCount++;
                interval = cyc - lastRise;
                lastRise = cyc;
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedRise", interval, 0);
                end else begin
                    expLen = expQ.pop_front();
                    checkOutput("period", interval, expLen);
                end
            end
            prevD = dco_clk;
        end
    end

    // Global watchdog so the run always ends.
    initial begin
        #400us;
        assertCount++;
        failCount++;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        finishTest();
    end

    // Main directed sequence.
    initial begin
        #2 rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("lowInReset", dco_clk, 0);
        end
        $display("[TB] reset release, first rise expected after 8 cycles");
        expectPeriod(8);
        #5 rst_n = 1'b0;
        waitAllRises();

        // Nominal period with 8 high / 8 low.
        expectPeriod(16);
        repeat (7) @(negedge clk);
        checkOutput("highAtCnt15", dco_clk, 1);
        @(negedge clk);
        checkOutput("lowAtCnt0", dco_clk, 0);
        waitAllRises();

        // Single add pulse while cnt=3.
        expectPeriod(15);
        expectPeriod(16);
        applyStimulus(11, 1, 1, 1, 0, 0, 1, 0);
        waitAllRises();

        // Single sub pulse while cnt=3.
        expectPeriod(17);
        expectPeriod(16);
        applyStimulus(0, 0, 1, 0, 11, 1, 1, 1);
        waitAllRises();

        // Add at cnt=6 skips cnt=7 so dco_clk rises one cycle early.
        expectPeriod(15);
        applyStimulus(14, 1, 1, 1, 0, 0, 1, 0);
        waitAllRises();

        // Wrap cases: add at cnt=14 lands on 0, add at cnt=15 lands on 1.
        expectPeriod(15);
        applyStimulus(6, 1, 1, 1, 0, 0, 1, 0);
        waitAllRises();
        expectPeriod(15);
        applyStimulus(7, 1, 1, 1, 0, 0, 1, 0);
        waitAllRises();

        // Simultaneous add and sub edges cancel.
        expectPeriod(16);
        applyStimulus(11, 1, 1, 1, 11, 1, 1, 1);
        waitAllRises();

        // 20 sub pulses two cycles apart: 20 cycles of total delay.
        expectPeriod(30);
        expectPeriod(22);
        expectPeriod(16);
        applyStimulus(0, 0, 1, 0, 2, 1, 2, 20);
        waitAllRises();

        // add held 5 cycles, once per period, 20 times.
        for (int r = 0; r < 20; r++) begin
`ifdef DCO_LEVEL_CORR_EN
            expectPeriod(11);
`else
            expectPeriod(15);
`endif
            applyStimulus(2, 5, 1, 1, 0, 0, 1, 0);
            waitAllRises();
        end

        // add held 10 cycles, 20 times.
        for (int r = 0; r < 20; r++) begin
`ifdef DCO_LEVEL_CORR_EN
            expectPeriod(9);
            expectPeriod(13);
`else
            expectPeriod(15);
`endif
            applyStimulus(2, 10, 1, 1, 0, 0, 1, 0);
            waitAllRises();
        end

        // add/sub alternating each cycle, 20 pulses: no net shift.
        expectPeriod(15);
        expectPeriod(17);
        applyStimulus(2, 1, 2, 10, 3, 1, 2, 10);
        waitAllRises();

        // Asynchronous reset in the middle of the high phase.
        repeat (3) @(negedge clk);
        checkOutput("highBeforeReset", dco_clk, 1);
        #3 rst_n = 1'b1;
        #1 checkOutput("asyncResetLow", dco_clk, 0);
        repeat (2) begin
            @(negedge clk);
            checkOutput("lowInMidReset", dco_clk, 0);
        end
        expectPeriod(8);
        expectPeriod(16);
        #5 rst_n = 1'b0;
        waitAllRises();

        checkOutput("queueEmpty", expQ.size(), 0);
        finishTest();
    end

endmodule
